// File: rtl/lcd_cmd_host.sv
// Purpose: command FIFO + sequencer for the LCD image controller; waits for done, then reads back and sums the result image.
// Latency: push to cmd_valid 2 cycles; done to first rb_rd 1 cycle; chk_valid 66 cycles after readback starts.
// Backpressure: in_ready low while the FIFO is full; issue is held off while busy is high in IDLE.
// Build option: define LCD_CMD_HOST_CHKSUM_EN for result-RAM readback and checksum; otherwise done reports chk=0.

// Purpose: single-clock FIFO with registered full/empty flags.
// Latency: a pushed entry is visible at head one cycle after the push edge (no bypass).
// Backpressure: pushes while full and pops while empty are ignored.
module lcd_cmd_fifo #(
    parameter int W     = 4,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] P_ONE  = AW'(1);
    localparam logic [AW:0]   C_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   C_LAST = (AW+1)'(DEPTH-1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + P_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + P_ONE;
            case ({do_push, do_pop})
                2'b10: begin
                    count <= count + C_ONE;
                    empty <= 1'b0;
                    full  <= (count == C_LAST);
                end
                2'b01: begin
                    count <= count - C_ONE;
                    full  <= 1'b0;
                    empty <= (count == C_ONE);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end
endmodule

// Purpose: issues buffered commands to the controller, stops at code 0, waits for done, reports a pixel checksum.
// Latency: cmd_valid 2 cycles after an accepted push into an empty FIFO; issues at most every other cycle.
// Backpressure: in_ready = FIFO not full; busy gates issue only in IDLE; done timeout sets sticky err.
module lcd_cmd_host #(
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  in_cmd,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [3:0]  cmd,
    output logic        cmd_valid,
    input  logic        busy,
    input  logic        done,
    output logic        rb_rd,
    output logic [5:0]  rb_addr,
    input  logic [7:0]  rb_data,
    output logic [15:0] chk,
    output logic        chk_valid,
    output logic        err
);
    typedef enum logic [2:0] {IDLE, ISSUE, GAP, WAIT_DONE, READBACK, FINISH} state_t;

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] T_ONE  = TW'(1);

    state_t        state;
    logic          fifo_full;
    logic          fifo_empty;
    logic [3:0]    fifo_head;
    logic [TW-1:0] tcnt;

    assign in_ready = !fifo_full;

    lcd_cmd_fifo #(.W(4), .DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (in_valid),
        .push_dat (in_cmd),
        .pop      (state == ISSUE),
        .head     (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

`ifdef LCD_CMD_HOST_CHKSUM_EN
    logic        rd_d;
    logic [15:0] sum;
`else
    logic unused_rb;
    assign unused_rb = ^rb_data;
    assign rb_rd     = 1'b0;
    assign rb_addr   = '0;
    assign chk       = '0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cmd       <= '0;
            cmd_valid <= 1'b0;
            chk_valid <= 1'b0;
            err       <= 1'b0;
            tcnt      <= '0;
`ifdef LCD_CMD_HOST_CHKSUM_EN
            rb_rd     <= 1'b0;
            rb_addr   <= '0;
            rd_d      <= 1'b0;
            sum       <= '0;
            chk       <= '0;
`endif
        end else begin
            cmd_valid <= 1'b0;
            chk_valid <= 1'b0;
`ifdef LCD_CMD_HOST_CHKSUM_EN
            // RAM data lags the read strobe by one cycle
            rd_d      <= rb_rd;
`endif
            case (state)
                IDLE: begin
                    if (!fifo_empty && !busy) state <= ISSUE;
                end
                ISSUE: begin
                    cmd_valid <= 1'b1;
                    cmd       <= fifo_head;
                    state     <= GAP;
                end
                GAP: begin
                    if (cmd == 4'd0) begin
                        state <= WAIT_DONE;
                        tcnt  <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end
                WAIT_DONE: begin
                    if (done) begin
`ifdef LCD_CMD_HOST_CHKSUM_EN
                        state   <= READBACK;
                        rb_rd   <= 1'b1;
                        rb_addr <= '0;
                        sum     <= '0;
`else
                        state     <= FINISH;
                        chk_valid <= 1'b1;
`endif
                    end else if (tcnt == T_LAST) begin
                        err   <= 1'b1;
                        state <= IDLE;
                    end else begin
                        tcnt <= tcnt + T_ONE;
                    end
                end
                READBACK: begin
`ifdef LCD_CMD_HOST_CHKSUM_EN
                    if (rb_rd) begin
                        if (rb_addr == 6'd63) begin
                            rb_rd   <= 1'b0;
                            rb_addr <= '0;
                        end else begin
                            rb_addr <= rb_addr + 6'd1;
                        end
                    end
                    if (rd_d) sum <= sum + {8'd0, rb_data};
                    // last datum arrives the cycle after the strobe drops
                    if (rd_d && !rb_rd) state <= FINISH;
`else
                    state <= IDLE;
`endif
                end
                FINISH: begin
`ifdef LCD_CMD_HOST_CHKSUM_EN
                    chk_valid <= 1'b1;
                    chk       <= sum;
`endif
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/lcd_cmd_host.md
# lcd_cmd_host

Host-side command sequencer for the LCD image controller. Buffers a stream of 4-bit commands, issues them to the controller over the `cmd`/`cmd_valid`/`busy` handshake, and stops at the write command (code 0). It then waits for `done`, reads the 64-pixel result image back from the result RAM, and reports a checksum. It sits between the system command source and the controller/result-RAM pair.

## Interface
Parameters:
- `DEPTH`, 16: command FIFO depth, power of two, ≥2.
- `TIMEOUT`, 4096: max cycles in WAIT_DONE before error.

Ports:
- `clk` in 1: clock, all state on rising edge.
- `reset` in 1: reset, asynchronous, active-low.
- `in_cmd` in 4: command to enqueue.
- `in_valid` in 1: enqueue request; accepted when `in_valid && in_ready`.
- `in_ready` out 1: FIFO not full.
- `cmd` out 4: command to controller.
- `cmd_valid` out 1: one-cycle issue strobe.
- `busy` in 1: controller busy; no issue while high.
- `done` in 1: controller finished writing result image.
- `rb_rd` out 1: result-RAM read enable.
- `rb_addr` out 6: result-RAM read address.
- `rb_data` in 8: read data, valid one cycle after `rb_rd`.
- `chk` out 16: sum of 64 result pixels.
- `chk_valid` out 1: one-cycle strobe, `chk` valid.
- `err` out 1: sticky timeout flag.

## Operation
- FIFO: `DEPTH` entries, registered full/empty, no bypass; push when full is dropped (`in_ready`=0).
- States: IDLE, ISSUE, GAP, WAIT_DONE, READBACK, FINISH.
- IDLE: FIFO non-empty and `busy`=0 → ISSUE; else stay.
- ISSUE (1 cycle): `cmd_valid`=1, `cmd`=FIFO head, pop → GAP.
- GAP (1 cycle): `cmd_valid`=0; lets registered `busy` rise. Issued code 0 → WAIT_DONE, else → IDLE.
- WAIT_DONE: FIFO pushes still accepted, no issue. `done`=1 → READBACK. Timeout counter reaching `TIMEOUT` → `err`=1, → IDLE.
- READBACK: `rb_rd`=1 for 64 cycles, `rb_addr` 0..63 ascending; accumulate `rb_data` into 16-bit sum one cycle later (max 16320, no overflow). After 64th datum → FINISH.
- FINISH (1 cycle): `chk_valid`=1, `chk`=sum → IDLE; sum cleared on READBACK entry. `chk` holds until next FINISH.
- `cmd` holds last issued value between issues.
- `err` clears only on reset.

## Timing
- Reset values: `in_ready`=1, `cmd`=0, `cmd_valid`=0, `rb_rd`=0, `rb_addr`=0, `chk`=0, `chk_valid`=0, `err`=0; FIFO empty, state IDLE.
- Push-to-issue, empty FIFO, `busy`=0: `cmd_valid` high 2 cycles after the accepted push edge.
- Minimum issue spacing: 2 cycles (ISSUE+GAP).
- `busy` sampled in IDLE only; `busy` high in ISSUE/GAP is ignored.
- `done` ignored outside WAIT_DONE.
- `done` edge to first `rb_rd`: 1 cycle. `chk_valid`: 66 cycles after READBACK entry.
- Reset asserted mid-operation: all state, FIFO, and sum cleared immediately; outputs at reset values.

## Configuration
- `LCD_CMD_HOST_CHKSUM_EN` defined: READBACK and checksum as above.
- Not defined: WAIT_DONE with `done` goes directly to FINISH (`chk_valid` pulses, `chk`=0); `rb_rd`, `rb_addr` tied 0; no accumulator.

## Test plan
- Reset with `busy`=1; push 3 commands (1, 2, 0); release `busy` → three `cmd_valid` pulses, codes 1, 2, 0, each only while `busy`=0, ≥2 cycles apart.
- Push `DEPTH`+1 commands with `busy`=1 → `in_ready` drops after `DEPTH`, extra push dropped, exactly `DEPTH` issued after `busy` falls.
- Issue 0; RAM model holds all pixels 0xFF; pulse `done` → 64 reads at addresses 0..63, `chk`=0x3FC0 with one `chk_valid` pulse.
- Issue 0, never assert `done`, `TIMEOUT`=32 → `err`=1 after 32 cycles; state IDLE; next stream still issues.
- Assert reset during READBACK at address 20 → all outputs at reset values next cycle; fresh stream ending in 0 gives correct `chk`.
- Build without `LCD_CMD_HOST_CHKSUM_EN`: `done` → `chk_valid` next cycle, `chk`=0, `rb_rd` never high.
